// File: rtl/decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : decode_stage
// RV32I decoder feeding a 2-entry skid FIFO towards rename.
// Optional RV32M decode is enabled by defining RV32M_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module decode_stage #(
  parameter int ILLEGAL_PASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mispredict,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_4_in,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_4_out,
  output logic [31:0] imm_out,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_op,
  output logic [1:0]  fu_type,
  output logic [2:0]  mem_size,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        rd_we,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_load,
  output logic        is_store,
  output logic        illegal
);

  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_fence  = 7'b0001111;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;
  localparam logic [6:0] c_f7_mul  = 7'b0000001;

  localparam logic [3:0] c_alu_add  = 4'b0000;
  localparam logic [3:0] c_alu_pass = 4'b1111;

  localparam logic [1:0] c_fu_alu = 2'd0;
  localparam logic [1:0] c_fu_bru = 2'd1;
  localparam logic [1:0] c_fu_lsu = 2'd2;
  localparam logic [1:0] c_fu_mul = 2'd3;

  localparam bit c_pass = (ILLEGAL_PASS != 0);

`ifdef RV32M_EN
  localparam bit c_m_en = 1'b1;
`else
  localparam bit c_m_en = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [1:0]  fu_type;
    logic [2:0]  mem_size;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_we;
    logic        is_branch;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } dec_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        legal;
  logic        has_rd;
  dec_t        dec;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];
  assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                   instr_in[11:8], 1'b0};
  assign imm_u  = {instr_in[31:12], 12'h000};
  assign imm_j  = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                   instr_in[30:21], 1'b0};

  // Opcodes are matched on all 7 bits, so instr_in[1:0] != 2'b11 falls to default.
  always_comb begin
    legal  = 1'b0;
    has_rd = 1'b0;
    dec    = '0;
    case (opcode)
      c_opc_lui: begin
        legal      = 1'b1;
        has_rd     = 1'b1;
        dec.imm    = imm_u;
        dec.alu_op = c_alu_pass;
      end
      c_opc_auipc: begin
        legal      = 1'b1;
        has_rd     = 1'b1;
        dec.imm    = imm_u;
        dec.alu_op = c_alu_add;
      end
      c_opc_jal: begin
        legal       = 1'b1;
        has_rd      = 1'b1;
        dec.imm     = imm_j;
        dec.fu_type = c_fu_bru;
        dec.is_jump = 1'b1;
      end
      c_opc_jalr: begin
        legal        = (funct3 == 3'd0);
        has_rd       = 1'b1;
        dec.rs1_used = 1'b1;
        dec.imm      = imm_i;
        dec.fu_type  = c_fu_bru;
        dec.is_jump  = 1'b1;
      end
      c_opc_branch: begin
        legal         = (funct3 != 3'd2) && (funct3 != 3'd3);
        dec.rs1_used  = 1'b1;
        dec.rs2_used  = 1'b1;
        dec.imm       = imm_b;
        dec.fu_type   = c_fu_bru;
        dec.is_branch = 1'b1;
        dec.alu_op    = {1'b0, funct3};
      end
      c_opc_load: begin
        legal        = (funct3 != 3'd3) && (funct3 < 3'd6);
        has_rd       = 1'b1;
        dec.rs1_used = 1'b1;
        dec.imm      = imm_i;
        dec.fu_type  = c_fu_lsu;
        dec.is_load  = 1'b1;
        dec.mem_size = funct3;
      end
      c_opc_store: begin
        legal        = (funct3 < 3'd3);
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        dec.imm      = imm_s;
        dec.fu_type  = c_fu_lsu;
        dec.is_store = 1'b1;
        dec.mem_size = funct3;
      end
      c_opc_opimm: begin
        case (funct3)
          3'd1:    legal = (funct7 == c_f7_base);
          3'd5:    legal = (funct7 == c_f7_base) || (funct7 == c_f7_alt);
          default: legal = 1'b1;
        endcase
        has_rd       = 1'b1;
        dec.rs1_used = 1'b1;
        dec.imm      = imm_i;
        // Only the shift-right immediate uses funct7 to select SRA.
        dec.alu_op   = {(funct3 == 3'd5) && funct7[5], funct3};
      end
      c_opc_op: begin
        has_rd       = 1'b1;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        case (funct7)
          c_f7_base: begin
            legal      = 1'b1;
            dec.alu_op = {1'b0, funct3};
          end
          c_f7_alt: begin
            legal      = (funct3 == 3'd0) || (funct3 == 3'd5);
            dec.alu_op = {1'b1, funct3};
          end
          c_f7_mul: begin
            legal       = c_m_en;
            dec.fu_type = c_fu_mul;
            dec.alu_op  = {1'b0, funct3};
          end
          default: legal = 1'b0;
        endcase
      end
      c_opc_fence: begin
        legal = (funct3 == 3'd0);
      end
      default: legal = 1'b0;
    endcase

    dec.rs1   = dec.rs1_used ? instr_in[19:15] : 5'd0;
    dec.rs2   = dec.rs2_used ? instr_in[24:20] : 5'd0;
    dec.rd    = has_rd ? instr_in[11:7] : 5'd0;
    dec.rd_we = has_rd && (instr_in[11:7] != 5'd0);

    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.pc   = pc_in;
    dec.pc_4 = pc_4_in;
  end

  // Two-entry skid FIFO
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       rd_ptr_q;
  logic       rd_ptr_d;
  logic       wr_ptr_q;
  logic       wr_ptr_d;
  dec_t [1:0] slot_q;
  dec_t [1:0] slot_d;
  dec_t       head;
  logic       push;
  logic       pop;

  assign ready_in  = reset && (count_q != 2'd2);
  assign valid_out = (count_q != 2'd0);
  assign pop       = valid_out && ready_out;
  assign push      = valid_in && ready_in && (legal || c_pass);

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    slot_d   = slot_q;
    if (mispredict) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        slot_d[wr_ptr_q] = dec;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload needs no reset: every read is gated by valid_out.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign head      = valid_out ? slot_q[rd_ptr_q] : '0;
  assign pc_out    = head.pc;
  assign pc_4_out  = head.pc_4;
  assign imm_out   = head.imm;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign rd        = head.rd;
  assign alu_op    = head.alu_op;
  assign fu_type   = head.fu_type;
  assign mem_size  = head.mem_size;
  assign rs1_used  = head.rs1_used;
  assign rs2_used  = head.rs2_used;
  assign rd_we     = head.rd_we;
  assign is_branch = head.is_branch;
  assign is_jump   = head.is_jump;
  assign is_load   = head.is_load;
  assign is_store  = head.is_store;
  assign illegal   = head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_decode_stage
// Directed bench for decode_stage with a queue-based reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_decode_stage;

  localparam int PASS = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [1:0]  fu;
    logic [2:0]  msize;
    logic        r1u;
    logic        r2u;
    logic        we;
    logic        br;
    logic        jmp;
    logic        ld;
    logic        st;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, mispredict, valid_in, ready_out;
  logic [31:0] instr_in, pc_in, pc_4_in;

  logic        ready_in, valid_out;
  logic [31:0] pc_out, pc_4_out, imm_out;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic [1:0]  fu_type;
  logic [2:0]  mem_size;
  logic        rs1_used, rs2_used, rd_we, is_branch, is_jump, is_load, is_store, illegal;

  logic        d_ready_in, d_valid_out;
  logic [31:0] d_pc_out, d_pc_4_out, d_imm_out;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [3:0]  d_alu_op;
  logic [1:0]  d_fu_type;
  logic [2:0]  d_mem_size;
  logic        d_rs1_used, d_rs2_used, d_rd_we, d_is_branch, d_is_jump, d_is_load;
  logic        d_is_store, d_illegal;

  always #5 clk = ~clk;

  decode_stage #(.ILLEGAL_PASS(PASS)) dut (
    .clk(clk), .reset(reset), .mispredict(mispredict),
    .valid_in(valid_in), .ready_in(ready_in),
    .instr_in(instr_in), .pc_in(pc_in), .pc_4_in(pc_4_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .pc_out(pc_out), .pc_4_out(pc_4_out), .imm_out(imm_out),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .fu_type(fu_type),
    .mem_size(mem_size), .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_we(rd_we),
    .is_branch(is_branch), .is_jump(is_jump), .is_load(is_load),
    .is_store(is_store), .illegal(illegal)
  );

  // Second instance drops illegal encodings and is always drained.
  decode_stage #(.ILLEGAL_PASS(0)) dut_drop (
    .clk(clk), .reset(reset), .mispredict(mispredict),
    .valid_in(valid_in), .ready_in(d_ready_in),
    .instr_in(instr_in), .pc_in(pc_in), .pc_4_in(pc_4_in),
    .valid_out(d_valid_out), .ready_out(1'b1),
    .pc_out(d_pc_out), .pc_4_out(d_pc_4_out), .imm_out(d_imm_out),
    .rs1(d_rs1), .rs2(d_rs2), .rd(d_rd), .alu_op(d_alu_op), .fu_type(d_fu_type),
    .mem_size(d_mem_size), .rs1_used(d_rs1_used), .rs2_used(d_rs2_used),
    .rd_we(d_rd_we), .is_branch(d_is_branch), .is_jump(d_is_jump),
    .is_load(d_is_load), .is_store(d_is_store), .illegal(d_illegal)
  );

  logic [127:0] got_vec, d_got_vec;
  assign got_vec = {pc_out, pc_4_out, imm_out, rs1, rs2, rd, alu_op, fu_type, mem_size,
                    rs1_used, rs2_used, rd_we, is_branch, is_jump, is_load, is_store, illegal};
  assign d_got_vec = {d_pc_out, d_pc_4_out, d_imm_out, d_rs1, d_rs2, d_rd, d_alu_op,
                      d_fu_type, d_mem_size, d_rs1_used, d_rs2_used, d_rd_we, d_is_branch,
                      d_is_jump, d_is_load, d_is_store, d_illegal};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode: classify the instruction into a format, then derive fields.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] pc4);
    exp_t        e;
    byte         fmt;
    bit          ok;
    int          f3;
    logic [6:0]  f7;
    bit          has_rd;
    e   = '0;
    fmt = "N";
    ok  = 0;
    f3  = int'(ins[14:12]);
    f7  = ins[31:25];
    case (ins[6:0])
      7'h37: begin ok = 1; fmt = "U"; e.alu = 4'hF; end
      7'h17: begin ok = 1; fmt = "U"; end
      7'h6F: begin ok = 1; fmt = "J"; e.fu = 1; e.jmp = 1; end
      7'h67: begin ok = (f3 == 0); fmt = "I"; e.fu = 1; e.jmp = 1; end
      7'h63: begin ok = !(f3 == 2 || f3 == 3); fmt = "B"; e.fu = 1; e.br = 1; e.alu = 4'(f3); end
      7'h03: begin ok = f3 inside {0, 1, 2, 4, 5}; fmt = "I"; e.fu = 2; e.ld = 1; e.msize = 3'(f3); end
      7'h23: begin ok = (f3 <= 2); fmt = "S"; e.fu = 2; e.st = 1; e.msize = 3'(f3); end
      7'h13: begin
        fmt = "I";
        if (f3 == 1) ok = (f7 == 7'h00);
        else if (f3 == 5) ok = (f7 == 7'h00 || f7 == 7'h20);
        else ok = 1;
        e.alu = (f3 == 5 && f7 == 7'h20) ? 4'hD : 4'(f3);
      end
      7'h33: begin
        fmt = "R";
        if (f7 == 7'h00) begin ok = 1; e.alu = 4'(f3); end
        else if (f7 == 7'h20) begin ok = (f3 == 0 || f3 == 5); e.alu = 4'(8 + f3); end
        else if (f7 == 7'h01) begin
`ifdef RV32M_EN
          ok = 1;
`else
          ok = 0;
`endif
          e.fu = 3; e.alu = 4'(f3);
        end
      end
      7'h0F: ok = (f3 == 0);
      default: ok = 0;
    endcase
    case (fmt)
      "I": e.imm = 32'(signed'(ins[31:20]));
      "S": e.imm = 32'(signed'({ins[31:25], ins[11:7]}));
      "B": e.imm = 32'(signed'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      "U": e.imm = {ins[31:12], 12'h000};
      "J": e.imm = 32'(signed'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default: e.imm = 32'h0;
    endcase
    e.r1u  = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
    e.r2u  = (fmt == "R" || fmt == "S" || fmt == "B");
    has_rd = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J");
    e.rs1  = e.r1u ? ins[19:15] : 5'd0;
    e.rs2  = e.r2u ? ins[24:20] : 5'd0;
    e.rd   = has_rd ? ins[11:7] : 5'd0;
    e.we   = has_rd && (ins[11:7] != 5'd0);
    if (!ok) begin
      e     = '0;
      e.ill = 1;
    end
    e.pc  = pc;
    e.pc4 = pc4;
    return e;
  endfunction

  exp_t q[$];
  exp_t qd[$];
  bit   started = 1'b0;

  task automatic model_step();
    exp_t e;
    bit   pop, push;
    e = model_decode(instr_in, pc_in, pc_4_in);
    if (!reset || mispredict) begin
      q.delete();
      qd.delete();
      return;
    end
    pop  = (q.size() != 0) && ready_out;
    push = valid_in && (q.size() < 2);
    if (pop) void'(q.pop_front());
    if (push && (PASS != 0 || !e.ill)) q.push_back(e);
    if (qd.size() != 0) void'(qd.pop_front());
    if (valid_in && !e.ill) qd.push_back(e);
  endtask

  function automatic exp_t head_q();
    if (q.size() != 0) return q[0];
    return '0;
  endfunction

  function automatic exp_t head_qd();
    if (qd.size() != 0) return qd[0];
    return '0;
  endfunction

  always @(posedge clk) begin
    model_step();
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("valid_out", valid_out, q.size() != 0);
      check("ready_in", ready_in, reset && (q.size() < 2));
      check("fields", got_vec, head_q());
      check("drop_valid_out", d_valid_out, qd.size() != 0);
      check("drop_ready_in", d_ready_in, reset);
      check("drop_fields", d_got_vec, head_qd());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    instr_in = ins;
    pc_in    = pc;
    pc_4_in  = pc + 32'd4;
    valid_in = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (ready_in) begin
        tick();
        valid_in = 1'b0;
        return;
      end
      tick();
    end
    check("send_timeout_ready_in", ready_in, 1'b1);
    valid_in = 1'b0;
  endtask

  logic [31:0] table_instr [22] = '{
    32'h123453B7, 32'hFFFFF417, 32'hFF9FF0EF, 32'h00008067, 32'h00208863,
    32'h0020A863, 32'hFE532E23, 32'h00520023, 32'h00419193, 32'h40225213,
    32'h40419193, 32'h407302B3, 32'h00A4F433, 32'h40A4E433, 32'h0FF0000F,
    32'h0000B183, 32'h00000001, 32'h00000013, 32'h00000073, 32'hFFF12093,
    32'h00044283, 32'h022081B3
  };

  exp_t m;

  initial begin
    reset      = 1'b0;
    mispredict = 1'b0;
    valid_in   = 1'b0;
    ready_out  = 1'b1;
    instr_in   = 32'h0;
    pc_in      = 32'h0;
    pc_4_in    = 32'h0;

    // Hand-computed pins on the reference decode
    m = model_decode(32'h00510093, 32'h100, 32'h104);
    check("pin_addi", {m.rd, m.rs1, m.imm, m.we, m.fu, m.r2u}, {5'd1, 5'd2, 32'd5, 1'b1, 2'd0, 1'b0});
    m = model_decode(32'hFFC32283, 32'h0, 32'h4);
    check("pin_lw", {m.ld, m.msize, m.imm, m.rs1, m.rd, m.fu}, {1'b1, 3'd2, 32'hFFFFFFFC, 5'd6, 5'd5, 2'd2});
    m = model_decode(32'h00208863, 32'h0, 32'h4);
    check("pin_beq_imm", {m.imm, m.br, m.rd, m.we}, {32'd16, 1'b1, 5'd0, 1'b0});
    m = model_decode(32'hFE532E23, 32'h0, 32'h4);
    check("pin_sw_imm", {m.imm, m.st, m.rs2}, {32'hFFFFFFFC, 1'b1, 5'd5});
    m = model_decode(32'hFF9FF0EF, 32'h0, 32'h4);
    check("pin_jal_imm", {m.imm, m.jmp, m.rd}, {32'hFFFFFFF8, 1'b1, 5'd1});
    m = model_decode(32'h40225213, 32'h0, 32'h4);
    check("pin_srai", {m.alu, m.imm}, {4'hD, 32'h402});
    m = model_decode(32'h0000B183, 32'h20, 32'h24);
    check("pin_illegal", {m.ill, m.we, m.fu, m.pc}, {1'b1, 1'b0, 2'd0, 32'h20});

    repeat (3) begin
      tick();
      check("reset_valid_out", valid_out, 1'b0);
      check("reset_ready_in", ready_in, 1'b0);
    end
    reset = 1'b1;
    #1;
    check("release_ready_in", ready_in, 1'b1);

    send(32'h00510093, 32'h100);
    check("addi_out", {valid_out, rd, rs1, imm_out, rd_we, fu_type, pc_4_out},
          {1'b1, 5'd1, 5'd2, 32'd5, 1'b1, 2'd0, 32'h104});
    send(32'hFFC32283, 32'h104);
    check("lw_out", {is_load, mem_size, imm_out, rs1, rd, fu_type},
          {1'b1, 3'd2, 32'hFFFFFFFC, 5'd6, 5'd5, 2'd2});

    for (int k = 0; k < 22; k++) begin
      ready_out = (k % 3) != 2;
      send(table_instr[k], 32'h200 + 32'(k) * 4);
    end
    ready_out = 1'b1;
    repeat (3) tick();

    // Backpressure: two accepted, third stalls, then drain in order
    ready_out = 1'b0;
    send(32'h00110113, 32'h300);
    send(32'h00210113, 32'h304);
    instr_in = 32'h00310113; pc_in = 32'h308; pc_4_in = 32'h30C; valid_in = 1'b1;
    #1;
    check("full_ready_in", ready_in, 1'b0);
    check("full_head_pc", {valid_out, pc_out}, {1'b1, 32'h300});
    tick();
    check("stall_head_pc", pc_out, 32'h300);
    ready_out = 1'b1;
    send(32'h00310113, 32'h308);
    repeat (3) tick();
    check("drained", valid_out, 1'b0);

    // Flush with two held entries and a pending input
    ready_out = 1'b0;
    send(32'h00410113, 32'h400);
    send(32'h00510113, 32'h404);
    instr_in = 32'h00610113; pc_in = 32'h408; pc_4_in = 32'h40C; valid_in = 1'b1;
    mispredict = 1'b1;
    tick();
    mispredict = 1'b0;
    valid_in   = 1'b0;
    check("flush_valid_out", valid_out, 1'b0);
    check("flush_ready_in", ready_in, 1'b1);
    // Flush with one held entry while an input is accepted
    send(32'h00710113, 32'h410);
    instr_in = 32'h00810113; pc_in = 32'h414; pc_4_in = 32'h418; valid_in = 1'b1;
    mispredict = 1'b1;
    tick();
    mispredict = 1'b0;
    valid_in   = 1'b0;
    check("flush1_valid_out", valid_out, 1'b0);
    ready_out = 1'b1;
    repeat (3) tick();

    send(32'h022081B3, 32'h500);
`ifdef RV32M_EN
    check("mul_out", {fu_type, illegal, alu_op}, {2'd3, 1'b0, 4'd0});
`else
    check("mul_out", {fu_type, illegal, rd_we}, {2'd0, 1'b1, 1'b0});
`endif
    tick();

    // Reset with one entry held and an input in flight
    ready_out = 1'b0;
    send(32'h00910113, 32'h600);
    reset    = 1'b0;
    instr_in = 32'h00A10113; pc_in = 32'h604; pc_4_in = 32'h608; valid_in = 1'b1;
    #1;
    check("midreset_ready_in", ready_in, 1'b0);
    tick();
    check("midreset_valid_out", valid_out, 1'b0);
    reset    = 1'b1;
    valid_in = 1'b0;
    ready_out = 1'b1;
    repeat (3) begin
      tick();
      check("post_reset_valid_out", valid_out, 1'b0);
    end
    send(32'h00B10113, 32'h700);
    check("post_reset_new_pc", {valid_out, pc_out}, {1'b1, 32'h700});
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
